gpio_controller: RTL and testbench
==================================

Name: gpio_controller

Overview:
Parametrised memory-mapped GPIO block for the core bus, the next generation of the basic LED/switch/key GPIO. It adds:
- configurable output and input channel widths;
- atomic set, clear and toggle writes on the output register;
- per-bit input synchronisation and debounce;
- edge capture with write-1-to-clear status;
- a masked, registered interrupt output.

It sits on the same AddressBus / DataReadBus / DataWriteBus / WriteAssert interface as the other peripherals.

Parameters:
- OUT_WIDTH, 16: number of output pins (1..32).
- IN_WIDTH, 14: number of input pins (1..32).
- OUT_RESET, 0: reset value of the output register (OUT_WIDTH bits).
- DEBOUNCE_CYCLES, 50000: consecutive cycles an input must disagree with its stable value before it is accepted (>=1).
- EDGE_MODE, 0: edges that set status. 0 = rising, 1 = falling, 2 = both.

Ports:
- CoreClock  in  1  single system clock; all state is on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- AddressBus  in  32  word address; only [15:0] is decoded.
- DataReadBus  out  32  read data, combinational from AddressBus, zero-extended.
- DataWriteBus  in  32  write data.
- WriteAssert  in  1  write strobe, sampled on CoreClock.
- GpioOut  out  OUT_WIDTH  driven directly from the output register.
- GpioIn  in  IN_WIDTH  raw asynchronous pins (switches/keys).
- Irq  out  1  registered interrupt, level, active high.

Behaviour:
- Register map (AddressBus[15:0]):
  - 0x0000 OUT: read/write.
  - 0x0001 OUT_SET: write-1-to-set OUT bits; reads 0.
  - 0x0002 OUT_CLR: write-1-to-clear OUT bits; reads 0.
  - 0x0003 OUT_TGL: write-1-to-toggle OUT bits; reads 0.
  - 0x1000 IN: read-only, debounced stable value.
  - 0x1001 EDGE_STATUS: read / write-1-to-clear.
  - 0x1002 IRQ_ENABLE: read/write.
- Unmapped addresses read 0 and ignore writes. Bits above a register's width read 0 and ignore writes.
- Writes take effect on the CoreClock edge where WriteAssert=1. A register read in the next cycle returns the new value. Reads have no side effects.
- Reset values:
  - OUT = OUT_RESET, so GpioOut = OUT_RESET.
  - Sync flops, stable value, debounce counters, EDGE_STATUS and IRQ_ENABLE = 0.
  - Irq = 0.
- Reset asserted mid-debounce or mid-operation aborts everything and restores these values immediately. Asynchronous assert does not wait for a clock edge.
- Input path, per bit:
  - Two-flop synchroniser feeds sync.
  - Counter cnt has width clog2(DEBOUNCE_CYCLES)+1.
  - If sync == stable: cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: stable <= sync and cnt <= 0.
  - Otherwise cnt <= cnt+1.
  - A pin change therefore appears in IN exactly 2+DEBOUNCE_CYCLES cycles after it is presented, assuming it is stable. Any glitch shorter than DEBOUNCE_CYCLES synced cycles never reaches IN.
- Edge detect: in the cycle after stable changes, EDGE_STATUS[i] <= 1 if the change matches EDGE_MODE. Flags are sticky until software clears them.
- Simultaneous W1C and new edge on the same bit: the set wins and the bit stays 1. W1C on other bits proceeds normally.
- Post-reset settling: an input held high through reset produces a rising edge once debounced. This is reported normally; software clears it.
- Irq <= |(EDGE_STATUS & IRQ_ENABLE) each cycle, i.e. one cycle after the status or enable change. It deasserts one cycle after the last enabled flag is cleared or masked.
- OUT updates apply to the named bits only. Unaffected bits hold. Writing 0 to SET, CLR or TGL is a no-op.

Test Plan:
1. Reset applied between clock edges -> GpioOut=OUT_RESET immediately, Irq=0. Reads: 0x0000=OUT_RESET, 0x1001=0, 0x1002=0. Reading 0x0004 or 0x2000 -> 0.
2. Write OUT=0x00F0, then SET 0x0003, then CLR 0x0010, then TGL 0x8001. Reading 0x0000 after each -> 0x00F0, 0x00F3, 0x00E3, 0x80E2. Reading 0x0001-0x0003 -> 0.
3. DEBOUNCE_CYCLES=8, GpioIn[0] pulse high for 6 cycles -> IN stays 0 and no status. Held high 20 cycles -> IN[0]=1 exactly 10 cycles after the rise.
4. EDGE_MODE=0, enable bit 2, debounced rise on bit 2 -> EDGE_STATUS=0x4 and Irq=1 one cycle later. W1C 0x4 -> status 0 and Irq=0 one cycle later. A falling edge sets no flag.
5. Write W1C 0x4 in the same cycle that a new bit-2 edge is flagged -> EDGE_STATUS bit 2 stays 1 and Irq stays 1.
6. Assert Reset at cnt=5 while the input is high -> cnt=0, IN=0. After release, IN rises 2+DEBOUNCE_CYCLES cycles later and EDGE_STATUS bit 0 sets.

Source files
------------

// File: rtl/gpio_controller.sv
// Memory-mapped GPIO: output register with atomic set/clear/toggle, debounced inputs,
// sticky edge status with write-1-to-clear, and a masked registered interrupt.
module gpio_controller #(
    parameter int                   OUT_WIDTH       = 16,
    parameter int                   IN_WIDTH        = 14,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET       = '0,
    parameter int                   DEBOUNCE_CYCLES = 50000,
    parameter int                   EDGE_MODE       = 0
) (
    input  logic                 CoreClock,
    input  logic                 Reset,
    input  logic [31:0]          AddressBus,
    output logic [31:0]          DataReadBus,
    input  logic [31:0]          DataWriteBus,
    input  logic                 WriteAssert,
    output logic [OUT_WIDTH-1:0] GpioOut,
    input  logic [IN_WIDTH-1:0]  GpioIn,
    output logic                 Irq
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [15:0] ADDR_OUT    = 16'h0000;
    localparam logic [15:0] ADDR_SET    = 16'h0001;
    localparam logic [15:0] ADDR_CLR    = 16'h0002;
    localparam logic [15:0] ADDR_TGL    = 16'h0003;
    localparam logic [15:0] ADDR_IN     = 16'h1000;
    localparam logic [15:0] ADDR_STATUS = 16'h1001;
    localparam logic [15:0] ADDR_ENABLE = 16'h1002;

    logic [15:0]          addr;
    logic [OUT_WIDTH-1:0] out_reg;
    logic [OUT_WIDTH-1:0] wr_out;
    logic [IN_WIDTH-1:0]  wr_in;
    logic [IN_WIDTH-1:0]  stable;
    logic [IN_WIDTH-1:0]  stable_prev;
    logic [IN_WIDTH-1:0]  status_reg;
    logic [IN_WIDTH-1:0]  enable_reg;
    logic [IN_WIDTH-1:0]  edge_set;
    logic                 irq_reg;
    logic                 unused_bits;

    assign addr        = AddressBus[15:0];
    assign wr_out      = DataWriteBus[OUT_WIDTH-1:0];
    assign wr_in       = DataWriteBus[IN_WIDTH-1:0];
    assign unused_bits = ^{AddressBus[31:16], DataWriteBus};

    // Per-pin synchroniser and debounce: a new level is accepted only after the
    // synchronised value has disagreed with the stable one for DEBOUNCE_CYCLES cycles.
    for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_in
        logic             meta;
        logic             sync;
        logic             stable_bit;
        logic [CNT_W-1:0] cnt;

        always_ff @(posedge CoreClock or posedge Reset) begin
            if (Reset) begin
                meta       <= 1'b0;
                sync       <= 1'b0;
                stable_bit <= 1'b0;
                cnt        <= '0;
            end else begin
                meta <= GpioIn[gi];
                sync <= meta;
                if (sync == stable_bit) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable_bit <= sync;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign stable[gi] = stable_bit;
    end

    always_comb begin
        edge_set = '0;
        if (EDGE_MODE == 0) begin
            edge_set = stable & ~stable_prev;
        end else if (EDGE_MODE == 1) begin
            edge_set = ~stable & stable_prev;
        end else begin
            edge_set = stable ^ stable_prev;
        end
    end

    // A newly detected edge is OR-ed in after the W1C mask, so it survives a same-cycle clear.
    always_ff @(posedge CoreClock or posedge Reset) begin
        if (Reset) begin
            out_reg     <= OUT_RESET;
            stable_prev <= '0;
            status_reg  <= '0;
            enable_reg  <= '0;
            irq_reg     <= 1'b0;
        end else begin
            stable_prev <= stable;
            irq_reg     <= |(status_reg & enable_reg);
            status_reg  <= status_reg | edge_set;
            if (WriteAssert) begin
                case (addr)
                    ADDR_OUT:    out_reg    <= wr_out;
                    ADDR_SET:    out_reg    <= out_reg | wr_out;
                    ADDR_CLR:    out_reg    <= out_reg & ~wr_out;
                    ADDR_TGL:    out_reg    <= out_reg ^ wr_out;
                    ADDR_STATUS: status_reg <= (status_reg & ~wr_in) | edge_set;
                    ADDR_ENABLE: enable_reg <= wr_in;
                    default:     ;
                endcase
            end
        end
    end

    always_comb begin
        DataReadBus = '0;
        case (addr)
            ADDR_OUT:    DataReadBus = 32'(out_reg);
            ADDR_IN:     DataReadBus = 32'(stable);
            ADDR_STATUS: DataReadBus = 32'(status_reg);
            ADDR_ENABLE: DataReadBus = 32'(enable_reg);
            default:     DataReadBus = '0;
        endcase
    end

    assign GpioOut = out_reg;
    assign Irq     = irq_reg;

endmodule

// File: tb/tb_gpio_controller.sv
// Directed and randomized bench for gpio_controller, checked against a cycle-level
// reference model that derives debounced inputs from a sliding window of pin samples.
module tb_gpio_controller;
    localparam int          OW   = 16;
    localparam int          IW   = 14;
    localparam int          D    = 8;
    localparam int          EM   = 0;
    localparam logic [15:0] ORST = 16'hA5C3;

    logic          CoreClock = 1'b0;
    logic          Reset = 1'b0;
    logic [31:0]   AddressBus = '0;
    logic [31:0]   DataWriteBus = '0;
    logic          WriteAssert = 1'b0;
    logic [IW-1:0] GpioIn = '0;
    logic [31:0]   DataReadBus;
    logic [OW-1:0] GpioOut;
    logic          Irq;

    always #5 CoreClock = ~CoreClock;

    gpio_controller #(
        .OUT_WIDTH      (OW),
        .IN_WIDTH       (IW),
        .OUT_RESET      (ORST),
        .DEBOUNCE_CYCLES(D),
        .EDGE_MODE      (EM)
    ) dut (
        .CoreClock   (CoreClock),
        .Reset       (Reset),
        .AddressBus  (AddressBus),
        .DataReadBus (DataReadBus),
        .DataWriteBus(DataWriteBus),
        .WriteAssert (WriteAssert),
        .GpioOut     (GpioOut),
        .GpioIn      (GpioIn),
        .Irq         (Irq)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [OW-1:0] m_out;
    logic [IW-1:0] m_stable;
    logic [IW-1:0] m_prev;
    logic [IW-1:0] m_status;
    logic [IW-1:0] m_en;
    logic          m_irq;
    logic [IW-1:0] m_hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a[15:0])
            16'h0000: return 32'(m_out);
            16'h1000: return 32'(m_stable);
            16'h1001: return 32'(m_status);
            16'h1002: return 32'(m_en);
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_out    = ORST;
        m_stable = '0;
        m_prev   = '0;
        m_status = '0;
        m_en     = '0;
        m_irq    = 1'b0;
        m_hist.delete();
        repeat (D + 2) m_hist.push_back('0);
    endtask

    // One clock edge: predict, advance, compare outputs and the current read.
    task automatic cyc();
        logic [OW-1:0] n_out;
        logic [IW-1:0] n_stable, n_status, n_en, edge_set, wd_in;
        logic [OW-1:0] wd_out;
        logic          n_irq, all_diff;
        wd_out = DataWriteBus[OW-1:0];
        wd_in  = DataWriteBus[IW-1:0];
        if (EM == 0)      edge_set = m_stable & ~m_prev;
        else if (EM == 1) edge_set = ~m_stable & m_prev;
        else              edge_set = m_stable ^ m_prev;
        n_irq    = |(m_status & m_en);
        n_status = m_status | edge_set;
        n_out    = m_out;
        n_en     = m_en;
        if (WriteAssert) begin
            case (AddressBus[15:0])
                16'h0000: n_out = wd_out;
                16'h0001: n_out = m_out | wd_out;
                16'h0002: n_out = m_out & ~wd_out;
                16'h0003: n_out = m_out ^ wd_out;
                16'h1001: n_status = (m_status & ~wd_in) | edge_set;
                16'h1002: n_en = wd_in;
                default:  ;
            endcase
        end
        // Window holds pins sampled D+1 .. 2 edges ago (two-flop synchroniser delay).
        m_hist.push_back(GpioIn);
        void'(m_hist.pop_front());
        n_stable = m_stable;
        for (int i = 0; i < IW; i++) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) begin
                if (m_hist[k][i] == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff) n_stable[i] = ~m_stable[i];
        end
        @(posedge CoreClock);
        #1;
        m_prev   = m_stable;
        m_stable = n_stable;
        m_out    = n_out;
        m_status = n_status;
        m_en     = n_en;
        m_irq    = n_irq;
        check("gpio_out", 32'(GpioOut), 32'(m_out));
        check("irq", 32'(Irq), 32'(m_irq));
        check("read_model", DataReadBus, m_read(AddressBus));
    endtask

    task automatic idle(input int n);
        WriteAssert = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        AddressBus   = a;
        DataWriteBus = d;
        WriteAssert  = 1'b1;
        cyc();
        WriteAssert  = 1'b0;
        $display("write addr=0x%08h data=0x%08h", a, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        AddressBus  = a;
        WriteAssert = 1'b0;
        #1;
        check(tag, DataReadBus, exp);
        check({tag, "_model"}, DataReadBus, m_read(a));
    endtask

    // Asserts reset between clock edges and releases it after one edge.
    task automatic do_reset();
        #3;
        Reset = 1'b1;
        #1;
        model_reset();
        check("rst_gpio_out", 32'(GpioOut), 32'(ORST));
        check("rst_irq", 32'(Irq), 32'h0);
        check("rst_read", DataReadBus, m_read(AddressBus));
        @(posedge CoreClock);
        #1;
        Reset = 1'b0;
    endtask

    logic [31:0] addr_list [9] = '{32'h0000, 32'h0001, 32'h0002, 32'h0003, 32'h1000,
                                   32'h1001, 32'h1002, 32'h0004, 32'h2000};

    initial begin
        int b;
        logic [31:0] a;

        // Reset state and unmapped reads
        do_reset();
        rd(32'h0000, 32'(ORST), "rst_out_reg");
        rd(32'h1001, 32'h0, "rst_status");
        rd(32'h1002, 32'h0, "rst_enable");
        rd(32'h0004, 32'h0, "unmapped_0004");
        rd(32'h2000, 32'h0, "unmapped_2000");

        // Output register with atomic set/clear/toggle
        wr(32'h0000, 32'h0000_00F0);  rd(32'h0000, 32'h00F0, "out_write");
        wr(32'h0001, 32'h0000_0003);  rd(32'h0000, 32'h00F3, "out_set");
        wr(32'h0002, 32'h0000_0010);  rd(32'h0000, 32'h00E3, "out_clr");
        wr(32'h0003, 32'h0000_8001);  rd(32'h0000, 32'h80E2, "out_tgl");
        rd(32'h0001, 32'h0, "set_reads_0");
        rd(32'h0002, 32'h0, "clr_reads_0");
        rd(32'h0003, 32'h0, "tgl_reads_0");
        wr(32'h0004, 32'h0000_FFFF);  rd(32'h0000, 32'h80E2, "unmapped_wr_ignored");
        wr(32'h0001, 32'h0);          rd(32'h0000, 32'h80E2, "set_zero_noop");
        wr(32'h1000, 32'h0000_00FF);  rd(32'h1000, 32'h0, "in_readonly");

        // Short glitch is filtered, long pulse accepted after exactly 2+D cycles
        GpioIn[0] = 1'b1;
        idle(6);
        GpioIn[0] = 1'b0;
        idle(15);
        rd(32'h1000, 32'h0, "glitch_in");
        rd(32'h1001, 32'h0, "glitch_status");
        AddressBus = 32'h1000;
        GpioIn[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (k == 9)  check("in_before_debounce", 32'(DataReadBus[0]), 32'h0);
            if (k == 10) check("in_after_debounce", 32'(DataReadBus[0]), 32'h1);
        end
        GpioIn[0] = 1'b0;
        idle(12);
        rd(32'h1001, 32'h1, "rise_bit0_status");
        wr(32'h1001, 32'h1);
        rd(32'h1001, 32'h0, "bit0_cleared");

        // Rise on enabled bit 2 raises Irq; W1C drops it; fall sets nothing
        wr(32'h1002, 32'h4);
        AddressBus = 32'h1001;
        GpioIn[2] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 10) check("status_not_yet", DataReadBus, 32'h0);
            if (k == 11) begin
                check("status_bit2", DataReadBus, 32'h4);
                check("irq_lags_status", 32'(Irq), 32'h0);
            end
            if (k == 12) check("irq_asserted", 32'(Irq), 32'h1);
        end
        wr(32'h1001, 32'h4);
        check("irq_holds_one_cycle", 32'(Irq), 32'h1);
        rd(32'h1001, 32'h0, "w1c_status");
        cyc();
        check("irq_deasserted", 32'(Irq), 32'h0);
        GpioIn[2] = 1'b0;
        idle(14);
        rd(32'h1001, 32'h0, "fall_no_flag");
        check("fall_no_irq", 32'(Irq), 32'h0);

        // W1C in the same cycle a new edge is flagged: the set wins
        GpioIn[2] = 1'b1;
        idle(10);
        wr(32'h1001, 32'h4);
        rd(32'h1001, 32'h4, "collision_set_wins");
        cyc();
        check("collision_irq", 32'(Irq), 32'h1);
        cyc();
        check("collision_irq_stays", 32'(Irq), 32'h1);
        wr(32'h1001, 32'hFFFF_FFFF);
        GpioIn[2] = 1'b0;
        idle(14);

        // Reset mid-debounce with the input held high
        GpioIn[0] = 1'b1;
        idle(7);
        AddressBus = 32'h1000;
        do_reset();
        check("reset_in_zero", DataReadBus, 32'h0);
        for (int k = 1; k <= 11; k++) begin
            cyc();
            if (k == 9)  check("post_rst_in_low", 32'(DataReadBus[0]), 32'h0);
            if (k == 10) check("post_rst_in_high", 32'(DataReadBus[0]), 32'h1);
        end
        rd(32'h1001, 32'h1, "post_rst_edge");

        // Randomized traffic against the model
        wr(32'h1002, 32'h3FFF);
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(5) == 0) begin
                b = $urandom_range(IW - 1);
                GpioIn[b] = ~GpioIn[b];
            end
            a = addr_list[$urandom_range(8)];
            if ($urandom_range(9) < 3) begin
                wr(a, $urandom);
            end else begin
                AddressBus = a;
                idle(1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
